// File: rtl/inst_fetch.sv
// Instruction fetch: issues pc to memory under queue credit, tags responses with their
// address, queues {pc, inst} for decode, and kills in-flight responses on redirect (br).
// Optional macro IFQ_BYPASS_EN forwards a kept response straight to decode when the queue is empty.
module inst_fetch #(
   parameter int QDEPTH    = 4,
   parameter int MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        ce,
   input  logic        br,
   output logic        stallreq,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   input  logic        id_ready
);
   localparam int QW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTST - 1);

   logic [CW-1:0] count_q, count_d;
   logic [QW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] outst_q, outst_d, kill_q, kill_d;
   logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

   logic [31:0] iq_pc_q   [QDEPTH];
   logic [31:0] iq_inst_q [QDEPTH];
   logic [31:0] tag_q     [MAX_OUTST];

   logic credit_ok, accept, rsp, kept, bypass, push, pop, head_vld;

   // Credit counts both in-flight requests and queued entries so every response has a slot.
   assign credit_ok = (32'(outst_q) < 32'(MAX_OUTST)) &&
                      ((32'(outst_q) + 32'(count_q)) < 32'(QDEPTH));
   assign mem_addr  = pc;
   assign mem_req   = rst & ce & ~br & credit_ok;
   assign accept    = mem_req & mem_gnt;
   assign stallreq  = rst & ce & ~br & ~accept;

   // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
   assign rsp      = mem_rvalid & (outst_q != '0);
   assign kept     = rsp & (kill_q == '0) & ~br;
   assign head_vld = (count_q != '0);

`ifdef IFQ_BYPASS_EN
   assign bypass = kept & ~head_vld & id_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push     = kept & ~bypass;
   assign pop      = head_vld & id_ready;
   assign id_valid = head_vld | bypass;
   assign id_pc    = head_vld ? iq_pc_q[rd_ptr_q]   : (bypass ? tag_q[tag_rd_q] : 32'h0);
   assign id_inst  = head_vld ? iq_inst_q[rd_ptr_q] : (bypass ? mem_rdata       : 32'h0);

   always_comb begin
      outst_d = outst_q;
      if (accept && !rsp)      outst_d = outst_q + OW'(1);
      else if (!accept && rsp) outst_d = outst_q - OW'(1);

      kill_d = kill_q;
      if (br)                         kill_d = outst_q - OW'(rsp);
      else if (rsp && kill_q != '0)   kill_d = kill_q - OW'(1);

      tag_wr_d = tag_wr_q;
      tag_rd_d = tag_rd_q;
      if (br) begin
         tag_wr_d = '0;
         tag_rd_d = '0;
      end else begin
         if (accept) tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
         if (kept)   tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);
      end

      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (br) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push)        wr_ptr_d = wr_ptr_q + QW'(1);
         if (pop)         rd_ptr_d = rd_ptr_q + QW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         outst_q  <= '0;
         kill_q   <= '0;
         tag_wr_q <= '0;
         tag_rd_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         outst_q  <= outst_d;
         kill_q   <= kill_d;
         tag_wr_q <= tag_wr_d;
         tag_rd_q <= tag_rd_d;
      end
   end

   // Storage needs no reset: outputs are masked by occupancy.
   always_ff @(posedge clk) begin
      if (accept) tag_q[tag_wr_q] <= pc;
      if (push) begin
         iq_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
         iq_inst_q[wr_ptr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: acts as PC generator, memory and decode, checking every cycle
// against a queue-based model of accepted, in-flight and queued instructions.
module tb_inst_fetch;
   localparam int QDEPTH    = 4;
   localparam int MAX_OUTST = 2;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, rst, ce, br, stallreq, mem_req, mem_gnt, mem_rvalid;
   logic        id_valid, id_ready;
   logic [31:0] pc, mem_addr, mem_rdata, id_pc, id_inst;

   inst_fetch #(.QDEPTH(QDEPTH), .MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .rst(rst), .pc(pc), .ce(ce), .br(br), .stallreq(stallreq),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic [31:0] inst; bit live; } rsp_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   rsp_t pend[$];      // accepted, not yet answered (live=0 once a redirect made it stale)
   rsp_t orphan[$];    // accepted before a reset, still to be answered by memory
   ent_t mq[$];        // instructions decode should still see, in order
   logic [31:0] popped[$];

   int checks = 0, errors = 0, accepts = 0, rv_pct = 100;
   logic [31:0] br_tgt;
   logic obs_req, obs_stall, obs_valid;
   logic [31:0] obs_addr, obs_pc;

   task automatic run_cycle();
      bit rv, acc, exp_req, exp_stall, from_pend, kept, byp, exp_valid;
      logic [31:0] exp_pc, exp_inst;
      rsp_t r;
      rv = 1'b0;
      if ((orphan.size() + pend.size()) > 0) rv = ($urandom_range(99) < rv_pct);
      mem_rvalid = rv;
      mem_rdata  = 32'h0;
      if (rv) mem_rdata = (orphan.size() > 0) ? orphan[0].inst : pend[0].inst;
      #2;
      exp_req   = ce && !br && (pend.size() < MAX_OUTST) && ((pend.size() + mq.size()) < QDEPTH);
      acc       = exp_req && mem_gnt;
      exp_stall = ce && !br && !acc;
      from_pend = rv && (orphan.size() == 0);
      kept      = from_pend && pend[0].live && !br;
      byp       = BYP && kept && (mq.size() == 0) && id_ready;
      exp_valid = (mq.size() > 0) || byp;
      exp_pc    = 32'h0;
      exp_inst  = 32'h0;
      if (mq.size() > 0) begin
         exp_pc = mq[0].pc; exp_inst = mq[0].inst;
      end else if (byp) begin
         exp_pc = pend[0].addr; exp_inst = pend[0].inst;
      end
      obs_req = mem_req; obs_stall = stallreq; obs_valid = id_valid;
      obs_addr = mem_addr; obs_pc = id_pc;
      checks += 4;
      if (mem_req !== exp_req) begin
         errors++; $display("FAIL mem_req t=%0t got %b exp %b", $time, mem_req, exp_req);
      end
      if (stallreq !== exp_stall) begin
         errors++; $display("FAIL stallreq t=%0t got %b exp %b", $time, stallreq, exp_stall);
      end
      if (mem_addr !== pc) begin
         errors++; $display("FAIL mem_addr t=%0t got %h exp %h", $time, mem_addr, pc);
      end
      if (id_valid !== exp_valid) begin
         errors++; $display("FAIL id_valid t=%0t got %b exp %b", $time, id_valid, exp_valid);
      end
      if (exp_valid) begin
         checks += 2;
         if (id_pc !== exp_pc) begin
            errors++; $display("FAIL id_pc t=%0t got %h exp %h", $time, id_pc, exp_pc);
         end
         if (id_inst !== exp_inst) begin
            errors++; $display("FAIL id_inst t=%0t got %h exp %h", $time, id_inst, exp_inst);
         end
      end
      @(posedge clk);
      if (exp_valid && id_ready) begin
         popped.push_back(exp_pc);
         if (mq.size() > 0) void'(mq.pop_front());
      end
      if (rv) begin
         if (orphan.size() > 0) void'(orphan.pop_front());
         else begin
            r = pend.pop_front();
            if (kept && !byp) mq.push_back('{pc: r.addr, inst: r.inst});
         end
      end
      if (acc) begin
         pend.push_back('{addr: pc, inst: $urandom, live: 1'b1});
         accepts++;
      end
      if (br) begin
         mq.delete();
         foreach (pend[i]) pend[i].live = 1'b0;
      end
      #1;
      if (br) pc = br_tgt;
      else if (acc) pc = pc + 32'd4;
   endtask

   task automatic drain();
      int n;
      ce = 1'b0; br = 1'b0; mem_gnt = 1'b1; id_ready = 1'b1; rv_pct = 100;
      n = 0;
      while ((pend.size() + orphan.size() + mq.size()) > 0 && n < 50) begin
         run_cycle(); n++;
      end
      checks++;
      if ((pend.size() + orphan.size() + mq.size()) > 0) begin
         errors++; $display("FAIL drain_timeout left %0d exp 0", pend.size() + mq.size());
      end
      popped.delete();
   endtask

   task automatic test_reset();
      checks += 5;
      if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
      if (stallreq !== 1'b0)  begin errors++; $display("FAIL rst_stallreq got %b exp 0", stallreq); end
      if (id_valid !== 1'b0)  begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
      if (id_pc !== 32'h0)    begin errors++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
      if (id_inst !== 32'h0)  begin errors++; $display("FAIL rst_id_inst got %h exp 0", id_inst); end
   endtask

   task automatic test_streaming();
      logic [31:0] want;
      drain();
      pc = 32'h0; ce = 1'b1; mem_gnt = 1'b1; id_ready = 1'b1; rv_pct = 100;
      repeat (8) begin
         run_cycle();
         checks++;
         if (obs_stall !== 1'b0) begin errors++; $display("FAIL stream_stall got %b exp 0", obs_stall); end
      end
      drain_keep_log();
      for (int i = 0; i < 3; i++) begin
         want = 32'(i * 4);
         checks++;
         if (popped.size() <= i || popped[i] !== want) begin
            errors++; $display("FAIL stream_order idx %0d got %h exp %h", i,
                               (popped.size() > i) ? popped[i] : 32'hx, want);
         end
      end
   endtask

   // Like drain but keeps the popped log for ordering checks.
   task automatic drain_keep_log();
      int n;
      ce = 1'b0; br = 1'b0; mem_gnt = 1'b1; id_ready = 1'b1; rv_pct = 100;
      n = 0;
      while ((pend.size() + mq.size()) > 0 && n < 50) begin
         run_cycle(); n++;
      end
   endtask

   task automatic test_backpressure();
      int a0;
      drain();
      pc = 32'h100; ce = 1'b1; mem_gnt = 1'b1; id_ready = 1'b0; rv_pct = 100;
      a0 = accepts;
      repeat (12) run_cycle();
      checks += 3;
      if (accepts - a0 != QDEPTH) begin
         errors++; $display("FAIL bp_accepts got %0d exp %0d", accepts - a0, QDEPTH);
      end
      if (obs_req !== 1'b0)   begin errors++; $display("FAIL bp_mem_req got %b exp 0", obs_req); end
      if (obs_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got %b exp 1", obs_stall); end
      id_ready = 1'b1;
      run_cycle();
      run_cycle();
      checks++;
      if (obs_req !== 1'b1) begin errors++; $display("FAIL bp_resume got %b exp 1", obs_req); end
      drain();
   endtask

   task automatic test_flush();
      drain();
      pc = 32'h10; ce = 1'b1; mem_gnt = 1'b1; id_ready = 1'b1; rv_pct = 0;
      repeat (2) run_cycle();
      br = 1'b1; br_tgt = 32'h80;
      run_cycle();
      br = 1'b0;
      checks++;
      if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", obs_stall); end
      rv_pct = 100;
      repeat (8) run_cycle();
      drain_keep_log();
      checks++;
      if (popped.size() == 0 || popped[0] !== 32'h80) begin
         errors++; $display("FAIL flush_first_pc got %h exp 00000080",
                            (popped.size() > 0) ? popped[0] : 32'hx);
      end
   endtask

   task automatic test_br_rvalid();
      drain();
      pc = 32'h200; ce = 1'b1; mem_gnt = 1'b1; id_ready = 1'b1; rv_pct = 0;
      repeat (2) run_cycle();
      br = 1'b1; br_tgt = 32'h300; rv_pct = 100;
      run_cycle();
      br = 1'b0; ce = 1'b0;
      run_cycle();
      run_cycle();
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL brrv_dropped got %b exp 0", obs_valid); end
      ce = 1'b1;
      run_cycle();
      drain_keep_log();
      checks++;
      if (popped.size() != 1 || popped[0] !== 32'h300) begin
         errors++; $display("FAIL brrv_resume got %0d pops exp 1 at 00000300", popped.size());
      end
   endtask

   task automatic test_gnt_stall();
      int a0;
      drain();
      pc = 32'h400; ce = 1'b1; mem_gnt = 1'b0; id_ready = 1'b1; rv_pct = 100;
      a0 = accepts;
      repeat (3) begin
         run_cycle();
         checks += 2;
         if (obs_stall !== 1'b1)      begin errors++; $display("FAIL gnt_stall got %b exp 1", obs_stall); end
         if (obs_addr !== 32'h400)    begin errors++; $display("FAIL gnt_pc_hold got %h exp 00000400", obs_addr); end
      end
      mem_gnt = 1'b1;
      run_cycle();
      ce = 1'b0;
      checks++;
      if (accepts - a0 != 1) begin errors++; $display("FAIL gnt_single got %0d exp 1", accepts - a0); end
      drain_keep_log();
      checks++;
      if (popped.size() != 1 || popped[0] !== 32'h400) begin
         errors++; $display("FAIL gnt_pop got %0d pops exp 1", popped.size());
      end
   endtask

   task automatic test_async_reset();
      int n;
      drain();
      pc = 32'h500; ce = 1'b1; mem_gnt = 1'b1; id_ready = 1'b0; rv_pct = 100;
      n = 0;
      while (mq.size() < 2 && n < 20) begin run_cycle(); n++; end
      rv_pct = 0;
      n = 0;
      while (pend.size() < 2 && n < 20) begin run_cycle(); n++; end
      #2 rst = 1'b0;
      #1;
      checks += 5;
      if (mem_req !== 1'b0)  begin errors++; $display("FAIL arst_mem_req got %b exp 0", mem_req); end
      if (stallreq !== 1'b0) begin errors++; $display("FAIL arst_stall got %b exp 0", stallreq); end
      if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_id_valid got %b exp 0", id_valid); end
      if (id_pc !== 32'h0)   begin errors++; $display("FAIL arst_id_pc got %h exp 0", id_pc); end
      if (id_inst !== 32'h0) begin errors++; $display("FAIL arst_id_inst got %h exp 0", id_inst); end
      orphan = pend;
      pend.delete();
      mq.delete();
      ce = 1'b0; id_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      rv_pct = 100;
      n = 0;
      while ((orphan.size() > 0 || n < 3) && n < 20) begin
         run_cycle(); n++;
         checks++;
         if (obs_valid !== 1'b0) begin errors++; $display("FAIL arst_orphan got %b exp 0", obs_valid); end
      end
      popped.delete();
      pc = 32'h600; ce = 1'b1;
      run_cycle();
      drain_keep_log();
      checks++;
      if (popped.size() != 1 || popped[0] !== 32'h600) begin
         errors++; $display("FAIL arst_fresh got %0d pops exp 1 at 00000600", popped.size());
      end
   endtask

   task automatic test_random();
      drain();
      pc = 32'h1000; rv_pct = 60;
      repeat (600) begin
         ce       = ($urandom_range(3) != 0);
         mem_gnt  = ($urandom_range(9) < 7);
         id_ready = ($urandom_range(9) < 7);
         br       = ($urandom_range(19) == 0);
         br_tgt   = 32'($urandom_range(1023)) << 2;
         run_cycle();
      end
      br = 1'b0;
      drain();
   endtask

   initial begin
      rst = 1'b0; ce = 1'b1; br = 1'b0; pc = 32'h100; mem_gnt = 1'b1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0; id_ready = 1'b1; br_tgt = 32'h0;
      repeat (2) @(posedge clk);
      #2 test_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      test_streaming();
      test_backpressure();
      test_flush();
      test_br_rvalid();
      test_gnt_stall();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
